// File: rtl/riscv_pkg.sv
// Shared encodings for the RV32I memory stage: funct3 load/store sizes,
// writeback result-source select and the load/store unit bus states.
package riscv_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] RS_ALU = 2'b00;
  localparam logic [1:0] RS_MEM = 2'b01;
  localparam logic [1:0] RS_PC4 = 2'b10;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_GNT = 2'd1,
    WAIT_RSP = 2'd2
  } lsu_state_t;

endpackage

// File: rtl/flopr.sv
// Plain register with synchronous active-high clear; building block of the MEM/WB boundary.
module flopr #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  // Capture D each cycle, clear on reset
  always_ff @(posedge i_clk) begin
    if (i_rst) r_q <= '0;
    else       r_q <= i_d;
  end

  assign o_q = r_q;

endmodule

// File: rtl/lsu_align.sv
// Byte-lane steering for the data bus: store strobes and replicated store data,
// load lane select with sign/zero extension, and natural-alignment detection.
module lsu_align
  import riscv_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic        o_aligned,
  output logic [3:0]  o_wstrb,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata_ext
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Lane selection and size-dependent strobe/data/extend generation
  always_comb begin
    w_byte      = i_rdata[7:0];
    w_half      = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
    o_aligned   = 1'b1;
    o_wstrb     = 4'b1111;
    o_wdata     = i_wdata;
    o_rdata_ext = i_rdata;
    case (i_addr_lo)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
    case (i_funct3[1:0])
      F3_B[1:0]: begin
        o_aligned   = 1'b1;
        o_wstrb     = 4'b0001 << i_addr_lo;
        o_wdata     = {4{i_wdata[7:0]}};
        // funct3[2] distinguishes the unsigned variants (bu/hu)
        o_rdata_ext = i_funct3[2] ? {24'b0, w_byte} : {{24{w_byte[7]}}, w_byte};
      end
      F3_H[1:0]: begin
        o_aligned   = ~i_addr_lo[0];
        o_wstrb     = 4'b0011 << i_addr_lo;
        o_wdata     = {2{i_wdata[15:0]}};
        o_rdata_ext = i_funct3[2] ? {16'b0, w_half} : {{16{w_half[15]}}, w_half};
      end
      default: begin
        o_aligned   = (i_addr_lo == 2'b00);
        o_wstrb     = 4'b1111;
        o_wdata     = i_wdata;
        o_rdata_ext = i_rdata;
      end
    endcase
  end

endmodule

// File: rtl/memory_stage_lsu.sv
// MEM stage of the RV32I pipeline: runs the data-memory req/grant/response
// handshake, stalls upstream while the bus is busy, aborts hung accesses,
// and holds the registered MEM/WB boundary feeding writeback.
module memory_stage_lsu
  import riscv_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  controlM,
  input  logic [2:0]  Funct3M,
  input  logic [31:0] AluResultM,
  input  logic [31:0] WriteDataM,
  input  logic [31:0] PcPlus4M,
  input  logic [4:0]  RdM,
  output logic        StallM,
  output logic        DmemReq,
  output logic        DmemWe,
  output logic [31:0] DmemAddr,
  output logic [3:0]  DmemWstrb,
  output logic [31:0] DmemWdata,
  input  logic        DmemGnt,
  input  logic        DmemRvalid,
  input  logic [31:0] DmemRdata,
  output logic [2:0]  controlW,
  output logic [31:0] AluResultW,
  output logic [31:0] ReadDataW,
  output logic [31:0] PcPlus4W,
  output logic [4:0]  RdW,
  output logic        MisalignW,
  output logic        BusErrW
);

  localparam int            CW       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

  lsu_state_t    r_state;
  lsu_state_t    w_state_nxt;
  logic [CW-1:0] r_tmo;

  logic        w_access, w_is_load, w_aligned, w_go, w_misalign;
  logic        w_req, w_done, w_tmo, w_stall, w_tmo_hit;
  logic [3:0]  w_wstrb;
  logic [31:0] w_wdata, w_rdata_ext;

  logic [2:0]  w_ctrl_d;
  logic [31:0] w_alu_d, w_rdata_d, w_pc4_d;
  logic [4:0]  w_rd_d;
  logic        w_mis_d, w_berr_d;

  assign w_access   = controlM[0] | (controlM[2:1] == RS_MEM);
  assign w_is_load  = w_access & ~controlM[0];
  assign w_go       = w_access & w_aligned;
  assign w_misalign = w_access & ~w_aligned;
  assign w_tmo_hit  = (r_tmo == TMO_LAST);

  lsu_align u_align (
    .i_funct3    (Funct3M),
    .i_addr_lo   (AluResultM[1:0]),
    .i_wdata     (WriteDataM),
    .i_rdata     (DmemRdata),
    .o_aligned   (w_aligned),
    .o_wstrb     (w_wstrb),
    .o_wdata     (w_wdata),
    .o_rdata_ext (w_rdata_ext)
  );

  // Bus handshake sequencing; timeout takes priority over a late grant/response
  always_comb begin
    w_state_nxt = r_state;
    w_req       = 1'b0;
    w_done      = 1'b0;
    w_tmo       = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_go) begin
          w_req = 1'b1;
          if (DmemGnt) begin
            if (w_is_load) w_state_nxt = WAIT_RSP;
            else           w_done      = 1'b1;
          end else begin
            w_state_nxt = WAIT_GNT;
          end
        end
      end
      WAIT_GNT: begin
        w_req = 1'b1;
        if (w_tmo_hit) begin
          w_tmo       = 1'b1;
          w_state_nxt = IDLE;
        end else if (DmemGnt) begin
          if (w_is_load) begin
            w_state_nxt = WAIT_RSP;
          end else begin
            w_done      = 1'b1;
            w_state_nxt = IDLE;
          end
        end
      end
      WAIT_RSP: begin
        if (w_tmo_hit) begin
          w_tmo       = 1'b1;
          w_state_nxt = IDLE;
        end else if (DmemRvalid) begin
          w_done      = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register; reset abandons any in-flight access
  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Wait-cycle counter: cleared while idle, counts every cycle spent waiting on the bus
  always_ff @(posedge clock) begin
    if (reset)                r_tmo <= '0;
    else if (r_state == IDLE) r_tmo <= '0;
    else                      r_tmo <= r_tmo + 1'b1;
  end

  assign w_stall   = w_go & ~w_done & ~w_tmo;
  assign StallM    = w_stall & ~reset;
  assign DmemReq   = w_req & ~reset;
  assign DmemWe    = DmemReq & controlM[0];
  assign DmemAddr  = DmemReq ? {AluResultM[31:2], 2'b00} : 32'b0;
  assign DmemWstrb = DmemReq ? w_wstrb : 4'b0;
  assign DmemWdata = DmemReq ? w_wdata : 32'b0;

  // MEM/WB D-input: bubble while stalled; misalign and bus error suppress RegWrite
  always_comb begin
    w_ctrl_d  = 3'b0;
    w_alu_d   = 32'b0;
    w_rdata_d = 32'b0;
    w_pc4_d   = 32'b0;
    w_rd_d    = 5'b0;
    w_mis_d   = 1'b0;
    w_berr_d  = 1'b0;
    if (!w_stall) begin
      w_ctrl_d  = {controlM[3] & ~w_misalign & ~w_tmo, controlM[2:1]};
      w_alu_d   = AluResultM;
      w_rdata_d = (w_done & w_is_load) ? w_rdata_ext : 32'b0;
      w_pc4_d   = PcPlus4M;
      w_rd_d    = RdM;
      w_mis_d   = w_misalign;
      w_berr_d  = w_tmo;
    end
  end

  flopr #(.WIDTH(3))  u_w_ctrl  (.i_clk(clock), .i_rst(reset), .i_d(w_ctrl_d),  .o_q(controlW));
  flopr #(.WIDTH(32)) u_w_alu   (.i_clk(clock), .i_rst(reset), .i_d(w_alu_d),   .o_q(AluResultW));
  flopr #(.WIDTH(32)) u_w_rdata (.i_clk(clock), .i_rst(reset), .i_d(w_rdata_d), .o_q(ReadDataW));
  flopr #(.WIDTH(32)) u_w_pc4   (.i_clk(clock), .i_rst(reset), .i_d(w_pc4_d),   .o_q(PcPlus4W));
  flopr #(.WIDTH(5))  u_w_rd    (.i_clk(clock), .i_rst(reset), .i_d(w_rd_d),    .o_q(RdW));
  flopr #(.WIDTH(1))  u_w_mis   (.i_clk(clock), .i_rst(reset), .i_d(w_mis_d),   .o_q(MisalignW));
  flopr #(.WIDTH(1))  u_w_berr  (.i_clk(clock), .i_rst(reset), .i_d(w_berr_d),  .o_q(BusErrW));

endmodule

// File: tb/tb_memory_stage_lsu.sv
// Bench for memory_stage_lsu: a per-instruction transaction model expands each
// instruction into per-cycle stimulus plus expected outputs; one negedge process
// compares the DUT against those expectations every cycle.
module tb_memory_stage_lsu;

  localparam int TIMEOUT = 64;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  controlM;
  logic [2:0]  Funct3M;
  logic [31:0] AluResultM, WriteDataM, PcPlus4M;
  logic [4:0]  RdM;
  logic        StallM, DmemReq, DmemWe;
  logic [31:0] DmemAddr, DmemWdata;
  logic [3:0]  DmemWstrb;
  logic        DmemGnt, DmemRvalid;
  logic [31:0] DmemRdata;
  logic [2:0]  controlW;
  logic [31:0] AluResultW, ReadDataW, PcPlus4W;
  logic [4:0]  RdW;
  logic        MisalignW, BusErrW;

  always #5 clock = ~clock;

  memory_stage_lsu #(.TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset), .controlM(controlM), .Funct3M(Funct3M),
    .AluResultM(AluResultM), .WriteDataM(WriteDataM), .PcPlus4M(PcPlus4M), .RdM(RdM),
    .StallM(StallM), .DmemReq(DmemReq), .DmemWe(DmemWe), .DmemAddr(DmemAddr),
    .DmemWstrb(DmemWstrb), .DmemWdata(DmemWdata), .DmemGnt(DmemGnt),
    .DmemRvalid(DmemRvalid), .DmemRdata(DmemRdata), .controlW(controlW),
    .AluResultW(AluResultW), .ReadDataW(ReadDataW), .PcPlus4W(PcPlus4W), .RdW(RdW),
    .MisalignW(MisalignW), .BusErrW(BusErrW)
  );

  typedef struct {
    logic        rst;
    logic [3:0]  ctrl;
    logic [2:0]  f3;
    logic [31:0] alu, wd, pc4;
    logic [4:0]  rd;
    logic        gnt, rvalid;
    logic [31:0] rdata;
    logic        e_stall, e_req, e_we;
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_strb;
    logic [2:0]  w_ctrl;
    logic [31:0] w_alu, w_pc4, w_rdata;
    logic [4:0]  w_rd;
    logic        w_mis, w_berr;
  } cyc_t;

  cyc_t        chk_q[$];
  int          total = 0;
  int          bad = 0;
  int          stall_seen = 0;
  int          req_seen = 0;
  logic [3:0]  last_strb = 4'h0;
  bit          use_rd = 1'b0;
  logic [31:0] fixed_rd = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int unsigned size_of(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  // Loaded value = the addressed bytes of the raw word, extended to 32 bits
  function automatic logic [31:0] ext_load(input logic [2:0] f3, input logic [31:0] addr,
                                           input logic [31:0] raw);
    int unsigned sz, span, v;
    sz = size_of(f3);
    if (sz == 4) return raw;
    span = 1 << (8 * sz);
    v = (raw >> (8 * (addr % 4))) % span;
    if (!f3[2] && v >= span / 2) return v - span;
    return v;
  endfunction

  function automatic cyc_t zero_rec();
    cyc_t c;
    c = '{default: 0};
    return c;
  endfunction

  task automatic apply(input cyc_t c);
    @(posedge clock);
    #1;
    reset      = c.rst;
    controlM   = c.ctrl;
    Funct3M    = c.f3;
    AluResultM = c.alu;
    WriteDataM = c.wd;
    PcPlus4M   = c.pc4;
    RdM        = c.rd;
    DmemGnt    = c.gnt;
    DmemRvalid = c.rvalid;
    DmemRdata  = c.rdata;
    chk_q.push_back(c);
  endtask

  // One instruction held in M: g = cycle index of grant, r = cycles from grant to rvalid
  task automatic run_op(input logic [3:0] ctrl, input logic [2:0] f3, input logic [31:0] alu,
                        input logic [31:0] wd, input logic [31:0] pc4, input logic [4:0] rd,
                        input int g, input int r);
    bit acc, ld, al, tmo;
    int unsigned sz;
    int n;
    cyc_t c;
    acc = ctrl[0] || (ctrl[2:1] == 2'b01);
    ld  = acc && !ctrl[0];
    sz  = size_of(f3);
    al  = (alu % sz) == 0;
    tmo = 1'b0;
    n   = 1;
    if (acc && al) begin
      n = ld ? g + r + 1 : g + 1;
      if (n - 1 >= TIMEOUT) begin
        tmo = 1'b1;
        n   = TIMEOUT + 1;
      end
    end
    for (int i = 0; i < n; i++) begin
      c        = zero_rec();
      c.ctrl   = ctrl; c.f3 = f3; c.alu = alu; c.wd = wd; c.pc4 = pc4; c.rd = rd;
      c.gnt    = acc && al && (i == g);
      c.rvalid = ld && al && (i == g + r);
      c.rdata  = use_rd ? fixed_rd : $urandom;
      c.e_stall = acc && al && (i < n - 1);
      c.e_req   = acc && al && (i <= g);
      c.e_we    = ctrl[0];
      c.e_addr  = alu & ~32'h3;
      c.e_strb  = 4'(((1 << sz) - 1) << (alu % 4));
      c.e_wdata = (sz == 1) ? {24'b0, wd[7:0]} * 32'h01010101 :
                  (sz == 2) ? {16'b0, wd[15:0]} * 32'h00010001 : wd;
      if (i == n - 1) begin
        c.w_ctrl  = {ctrl[3] && !(acc && !al) && !tmo, ctrl[2:1]};
        c.w_alu   = alu;
        c.w_pc4   = pc4;
        c.w_rd    = rd;
        c.w_rdata = (ld && al && !tmo) ? ext_load(f3, alu, c.rdata) : 32'h0;
        c.w_mis   = acc && !al;
        c.w_berr  = tmo;
      end
      apply(c);
    end
  endtask

  task automatic nop();
    run_op(4'b0000, 3'b000, 32'h0, 32'h0, 32'h0, 5'd0, 0, 0);
  endtask

  // Per-cycle comparison against the expanded model records
  initial begin : compare
    cyc_t c, p;
    bit   have_p;
    have_p = 1'b0;
    forever begin
      @(negedge clock);
      if (chk_q.size() > 0) begin
        c = chk_q.pop_front();
        if (have_p) begin
          check("controlW",   {29'b0, controlW}, {29'b0, p.w_ctrl});
          check("AluResultW", AluResultW, p.w_alu);
          check("PcPlus4W",   PcPlus4W, p.w_pc4);
          check("RdW",        {27'b0, RdW}, {27'b0, p.w_rd});
          check("ReadDataW",  ReadDataW, p.w_rdata);
          check("MisalignW",  {31'b0, MisalignW}, {31'b0, p.w_mis});
          check("BusErrW",    {31'b0, BusErrW}, {31'b0, p.w_berr});
        end
        check("StallM",  {31'b0, StallM}, {31'b0, c.e_stall});
        check("DmemReq", {31'b0, DmemReq}, {31'b0, c.e_req});
        if (StallM === 1'b1) stall_seen++;
        if (DmemReq === 1'b1) begin
          req_seen++;
          last_strb = DmemWstrb;
        end
        if (c.e_req) begin
          check("DmemWe",    {31'b0, DmemWe}, {31'b0, c.e_we});
          check("DmemAddr",  DmemAddr, c.e_addr);
          check("DmemWstrb", {28'b0, DmemWstrb}, {28'b0, c.e_strb});
          if (c.e_we) check("DmemWdata", DmemWdata, c.e_wdata);
        end
        p = c;
        have_p = 1'b1;
      end else begin
        have_p = 1'b0;
      end
    end
  end

  initial begin : stim
    cyc_t        c;
    int          s0, q0, kind, g, r;
    logic [3:0]  ctrl;
    logic [2:0]  f3;
    logic [31:0] alu;

    reset = 1'b1; controlM = 4'h0; Funct3M = 3'h0; AluResultM = 32'h0; WriteDataM = 32'h0;
    PcPlus4M = 32'h0; RdM = 5'h0; DmemGnt = 1'b0; DmemRvalid = 1'b0; DmemRdata = 32'h0;

    // Reset with an aligned load sitting in M: no request, no stall, W cleared
    for (int i = 0; i < 3; i++) begin
      c = zero_rec();
      c.rst = 1'b1; c.ctrl = 4'b1010; c.f3 = 3'b010; c.alu = 32'h10; c.rd = 5'd3;
      apply(c);
    end
    nop();
    check("reset_controlW", {29'b0, controlW}, 32'h0);
    check("reset_ReadDataW", ReadDataW, 32'h0);

    // sw 0x100 granted at once: full strobe, no stall, store does not write back
    s0 = stall_seen;
    run_op(4'b0001, 3'b010, 32'h100, 32'hDEADBEEF, 32'h44, 5'd0, 0, 0);
    nop();
    check("sw_strb", {28'b0, last_strb}, 32'hF);
    check("sw_stalls", stall_seen - s0, 0);
    check("sw_regwrite", {31'b0, controlW[2]}, 32'h0);

    // lb / lbu at 0x103 with 0x80 in the top byte, zero-wait bus
    use_rd = 1'b1; fixed_rd = 32'h80123456;
    s0 = stall_seen;
    run_op(4'b1010, 3'b000, 32'h103, 32'h0, 32'h48, 5'd5, 0, 1);
    nop();
    check("lb_sext", ReadDataW, 32'hFFFFFF80);
    check("lb_stalls", stall_seen - s0, 1);
    run_op(4'b1010, 3'b100, 32'h103, 32'h0, 32'h4C, 5'd6, 0, 1);
    nop();
    check("lbu_zext", ReadDataW, 32'h00000080);

    // lh at 0x202, grant after 3 cycles, response 2 cycles after grant
    fixed_rd = 32'h9ABC1234;
    s0 = stall_seen;
    run_op(4'b1010, 3'b001, 32'h202, 32'h0, 32'h50, 5'd7, 3, 2);
    nop();
    check("lh_stalls", stall_seen - s0, 5);
    check("lh_sext", ReadDataW, 32'hFFFF9ABC);
    use_rd = 1'b0;

    // lw at 0x106 is misaligned: no request, flagged, no writeback
    q0 = req_seen;
    run_op(4'b1010, 3'b010, 32'h106, 32'h0, 32'h54, 5'd8, 0, 1);
    nop();
    check("mis_reqs", req_seen - q0, 0);
    check("mis_flag", {31'b0, MisalignW}, 32'h1);
    check("mis_regwrite", {31'b0, controlW[2]}, 32'h0);

    // Grant never arrives: abort after TIMEOUT waiting cycles, then bus usable again
    s0 = stall_seen;
    run_op(4'b1001, 3'b010, 32'h40, 32'h12345678, 32'h58, 5'd9, 100000, 0);
    nop();
    check("tmo_stalls", stall_seen - s0, TIMEOUT);
    check("tmo_buserr", {31'b0, BusErrW}, 32'h1);
    s0 = stall_seen;
    run_op(4'b0001, 3'b000, 32'h41, 32'h000000A5, 32'h5C, 5'd0, 0, 0);
    nop();
    check("post_tmo_stalls", stall_seen - s0, 0);
    check("post_tmo_buserr", {31'b0, BusErrW}, 32'h0);

    // Reset while waiting for a load response; the late response is ignored
    c = zero_rec();
    c.ctrl = 4'b1010; c.f3 = 3'b000; c.alu = 32'h300; c.rd = 5'd4; c.gnt = 1'b1;
    c.e_stall = 1'b1; c.e_req = 1'b1; c.e_addr = 32'h300; c.e_strb = 4'b0001;
    apply(c);
    c.gnt = 1'b0; c.rst = 1'b1; c.e_stall = 1'b0; c.e_req = 1'b0;
    apply(c);
    nop();
    c = zero_rec();
    c.rvalid = 1'b1; c.rdata = 32'hCAFEF00D;
    apply(c);
    nop();
    check("rst_mid_ReadDataW", ReadDataW, 32'h0);
    check("rst_mid_controlW", {29'b0, controlW}, 32'h0);
    s0 = stall_seen;
    run_op(4'b0001, 3'b001, 32'h302, 32'h0000BEEF, 32'h60, 5'd0, 0, 0);
    nop();
    check("rst_mid_idle", stall_seen - s0, 0);

    // Randomized instruction mix against the model
    for (int k = 0; k < 300; k++) begin
      kind = $urandom_range(0, 3);
      alu  = $urandom;
      if ($urandom_range(0, 1) == 1) alu = alu & ~32'h3;
      f3 = 3'b000;
      case (kind)
        0: ctrl = {1'($urandom_range(0, 1)), 2'b00, 1'b0};
        1: ctrl = {1'($urandom_range(0, 1)), 2'b10, 1'b0};
        2: begin
          ctrl = {1'($urandom_range(0, 1)), 2'b01, 1'b0};
          case ($urandom_range(0, 4))
            0: f3 = 3'b000;
            1: f3 = 3'b001;
            2: f3 = 3'b010;
            3: f3 = 3'b100;
            default: f3 = 3'b101;
          endcase
        end
        default: begin
          ctrl = {1'($urandom_range(0, 1)), 2'b00, 1'b1};
          f3   = 3'($urandom_range(0, 2));
        end
      endcase
      g = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      r = $urandom_range(1, 3);
      run_op(ctrl, f3, alu, $urandom, $urandom, 5'($urandom), g, r);
    end

    nop();
    nop();
    @(posedge clock);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
